// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage. Holds the PC, issues in-order imem requests under a
// credit limit, buffers returned words in a small FIFO and presents them to decode with their PC.
// A redirect flushes the buffer, drops in-flight responses and restarts fetch at the target.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in FAULT.
module fetch_pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  localparam int unsigned     PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW      = PtrW + 1;
  localparam int unsigned     SumW      = CntW + 1;
  localparam logic [SumW-1:0] CreditMax = SumW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] FullCnt   = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] OneCnt    = CntW'(1);
  localparam logic [PtrW-1:0] OnePtr    = PtrW'(1);

  typedef enum logic [1:0] {StResetWait, StRun, StFault} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];

  logic            run;
  logic            fault_take;
  logic            redirect_take;
  logic            flush;
  logic            req_fire;
  logic            rsp_dec;
  logic            push;
  logic            pop;
  logic [SumW-1:0] credit_used;

  assign run = (state_q == StRun);

`ifdef FETCH_ALIGN_CHECK_EN
  assign fault_take  = run && redirect_valid && (redirect_addr[1:0] != 2'b00);
  assign fetch_fault = (state_q == StFault);
`else
  assign fault_take  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign redirect_take = run && redirect_valid && !fault_take;
  assign flush         = redirect_take || fault_take;

  // Outstanding requests plus buffered words may never exceed the buffer size.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = run && (credit_used < CreditMax) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Stale responses from before reset are not tracked, so never decrement below zero.
  assign rsp_dec = imem_rsp_valid && (outstanding_q != '0);
  // Responses in a redirect cycle belong to the old stream and are discarded.
  assign push    = imem_rsp_valid && run && !flush && (drop_cnt_q == '0);

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;

  // FSM next state: leave reset wait unconditionally, FAULT is sticky until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StResetWait: state_d = StRun;
      StRun:       if (fault_take) state_d = StFault;
      StFault:     state_d = StFault;
      default:     state_d = StResetWait;
    endcase
  end

  // Datapath next state: PC, response PC, credit counters and FIFO pointers.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (req_fire) pc_d = pc_q + XLEN'(4);

    case ({req_fire, rsp_dec})
      2'b10:   outstanding_d = outstanding_q + OneCnt;
      2'b01:   outstanding_d = outstanding_q - OneCnt;
      default: outstanding_d = outstanding_q;
    endcase

    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OneCnt;

    if (push) begin
      rsp_pc_d = rsp_pc_q + XLEN'(4);
      wr_ptr_d = wr_ptr_q + OnePtr;
    end
    if (pop) rd_ptr_d = rd_ptr_q + OnePtr;

    case ({push, pop})
      2'b10:   count_d = count_q + OneCnt;
      2'b01:   count_d = count_q - OneCnt;
      default: count_d = count_q;
    endcase

    // No request fires in a redirect cycle, so outstanding_d already excludes this
    // cycle's response: everything still in flight belongs to the old stream.
    if (redirect_take) begin
      pc_d       = redirect_addr;
      rsp_pc_d   = redirect_addr;
      drop_cnt_d = outstanding_d;
    end

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Control and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StResetWait;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Buffer storage: write the response word with the PC it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

`ifndef SYNTHESIS
  // Credit accounting must keep a response from landing in a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == FullCnt) && !pop))
    else $error("fetch_pc_unit: response written into full instruction buffer");
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with an in-order memory model of configurable latency.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_fetch_pc_unit;
  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] KEY        = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;
  int lat = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pc_log[$];
  logic [31:0] data_log[$];
  int          inst_cyc[$];

  fetch_pc_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and handshake monitor; a request seen in cycle k answers in cycle k+lat.
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_addr.pop_front() ^ KEY;
        void'(pend_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc - c0);
      end
      if (inst_valid && inst_ready) begin
        pc_log.push_back(inst_pc);
        data_log.push_back(inst_data);
        inst_cyc.push_back(cyc - c0);
      end
    end
  end

  // Hold reset, clear logs, release just after a rising edge; that cycle is c0.
  task automatic do_reset(input int l, input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b1;
    inst_ready     = rdy;
    lat            = l;
    repeat (2) @(posedge clk);
    #1;
    req_log.delete();
    req_cyc.delete();
    pc_log.delete();
    data_log.delete();
    inst_cyc.delete();
    rst_n = 1'b1;
    c0    = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(1, 1'b1);
    sample();
    checks += 6;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_wait_req_valid got=%b exp=0", imem_req_valid);
    end
    if (imem_req_addr !== RESET_PC) begin
      failures++; $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RESET_PC);
    end
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid);
    end
    if (inst_data !== 32'h0) begin
      failures++; $display("FAIL reset_inst_data got=%h exp=0", inst_data);
    end
    if (inst_pc !== 32'h0) begin
      failures++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc);
    end
    if (fetch_fault !== 1'b0) begin
      failures++; $display("FAIL reset_fetch_fault got=%b exp=0", fetch_fault);
    end
    // Running steadily by c5: head is the third word, another request is pending.
    step(5);
    sample();
    checks += 3;
    if (imem_req_valid !== 1'b1) begin
      failures++; $display("FAIL run_req_valid got=%b exp=1", imem_req_valid);
    end
    if (inst_pc !== 32'h8) begin
      failures++; $display("FAIL run_inst_pc got=%h exp=8", inst_pc);
    end
    if (inst_data !== (32'h8 ^ KEY)) begin
      failures++; $display("FAIL run_inst_data got=%h exp=%h", inst_data, 32'h8 ^ KEY);
    end
    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL async_req_valid got=%b exp=0", imem_req_valid);
    end
    if (imem_req_addr !== RESET_PC) begin
      failures++; $display("FAIL async_req_addr got=%h exp=%h", imem_req_addr, RESET_PC);
    end
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL async_inst_valid got=%b exp=0", inst_valid);
    end
    if (inst_pc !== 32'h0) begin
      failures++; $display("FAIL async_inst_pc got=%h exp=0", inst_pc);
    end
    if (inst_data !== 32'h0) begin
      failures++; $display("FAIL async_inst_data got=%h exp=0", inst_data);
    end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1);
    step(1);
    sample();
    checks += 2;
    if (imem_req_valid !== 1'b1) begin
      failures++; $display("FAIL first_req_valid got=%b exp=1", imem_req_valid);
    end
    if (imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL first_req_addr got=%h exp=0", imem_req_addr);
    end
    step(8);
    checks += 2;
    if (req_log.size() < 3) begin
      failures++; $display("FAIL stream_req_count got=%0d exp>=3", req_log.size());
    end
    if (pc_log.size() < 3) begin
      failures++; $display("FAIL stream_inst_count got=%0d exp>=3", pc_log.size());
    end
    for (int i = 0; i < 3 && i < req_log.size() && i < pc_log.size(); i++) begin
      checks += 5;
      if (req_log[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", i, req_log[i], 4 * i);
      end
      if (req_cyc[i] !== 1 + i) begin
        failures++; $display("FAIL stream_req_cycle[%0d] got=%0d exp=%0d", i, req_cyc[i], 1 + i);
      end
      if (pc_log[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL stream_inst_pc[%0d] got=%h exp=%h", i, pc_log[i], 4 * i);
      end
      if (data_log[i] !== (32'(4 * i) ^ KEY)) begin
        failures++; $display("FAIL stream_inst_data[%0d] got=%h", i, data_log[i]);
      end
      if (inst_cyc[i] !== 3 + i) begin
        failures++; $display("FAIL stream_inst_cycle[%0d] got=%0d exp=%0d", i, inst_cyc[i], 3 + i);
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1, 1'b0);
    step(10);
    sample();
    checks += 3;
    if (req_log.size() !== FIFO_DEPTH) begin
      failures++; $display("FAIL stall_req_count got=%0d exp=%0d", req_log.size(), FIFO_DEPTH);
    end
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid);
    end
    if (inst_valid !== 1'b1) begin
      failures++; $display("FAIL stall_inst_valid got=%b exp=1", inst_valid);
    end
    step(1);
    inst_ready = 1'b1;
    step(12);
    checks += 1;
    if (pc_log.size() < 8) begin
      failures++; $display("FAIL stall_resume_count got=%0d exp>=8", pc_log.size());
    end
    for (int i = 0; i < 8 && i < pc_log.size(); i++) begin
      checks += 2;
      if (pc_log[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL stall_resume_pc[%0d] got=%h exp=%h", i, pc_log[i], 4 * i);
      end
      if (data_log[i] !== (32'(4 * i) ^ KEY)) begin
        failures++; $display("FAIL stall_resume_data[%0d] got=%h", i, data_log[i]);
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset(3, 1'b1);
    step(3);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    sample();
    checks += 2;
    if (req_log.size() !== 2) begin
      failures++; $display("FAIL drop_outstanding got=%0d exp=2", req_log.size());
    end
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL drop_req_forced_low got=%b exp=0", imem_req_valid);
    end
    step(1);
    redirect_valid = 1'b0;
    sample();
    checks += 2;
    if (imem_req_valid !== 1'b1) begin
      failures++; $display("FAIL drop_new_req_valid got=%b exp=1", imem_req_valid);
    end
    if (imem_req_addr !== 32'h100) begin
      failures++; $display("FAIL drop_new_req_addr got=%h exp=100", imem_req_addr);
    end
    step(12);
    checks += 2;
    if (req_log.size() < 3 || req_log[2] !== 32'h100 || req_cyc[2] !== 4) begin
      failures++; $display("FAIL drop_req_after_redirect got=%h@%0d exp=100@4",
                           req_log[2], req_cyc[2]);
    end
    if (pc_log.size() < 2) begin
      failures++; $display("FAIL drop_inst_count got=%0d exp>=2", pc_log.size());
    end
    for (int i = 0; i < 2 && i < pc_log.size(); i++) begin
      checks += 2;
      if (pc_log[i] !== 32'h100 + 32'(4 * i)) begin
        failures++; $display("FAIL drop_inst_pc[%0d] got=%h exp=%h", i, pc_log[i], 'h100 + 4 * i);
      end
      if (data_log[i] !== ((32'h100 + 32'(4 * i)) ^ KEY)) begin
        failures++; $display("FAIL drop_inst_data[%0d] got=%h", i, data_log[i]);
      end
    end
  endtask

  task automatic test_redirect_collision();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h200, 32'h204};
    do_reset(3, 1'b1);
    step(6);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h200;
    sample();
    checks += 3;
    if (imem_rsp_valid !== 1'b1 || inst_valid !== 1'b1) begin
      failures++; $display("FAIL coll_setup rsp=%b inst=%b exp=1,1", imem_rsp_valid, inst_valid);
    end
    if (inst_pc !== 32'h4) begin
      failures++; $display("FAIL coll_head_pc got=%h exp=4", inst_pc);
    end
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL coll_req_forced_low got=%b exp=0", imem_req_valid);
    end
    step(1);
    redirect_valid = 1'b0;
    step(14);
    checks += 1;
    if (pc_log.size() < 4) begin
      failures++; $display("FAIL coll_inst_count got=%0d exp>=4", pc_log.size());
    end
    for (int i = 0; i < 4 && i < pc_log.size(); i++) begin
      checks += 2;
      if (pc_log[i] !== exp_pc[i]) begin
        failures++; $display("FAIL coll_inst_pc[%0d] got=%h exp=%h", i, pc_log[i], exp_pc[i]);
      end
      if (data_log[i] !== (exp_pc[i] ^ KEY)) begin
        failures++; $display("FAIL coll_inst_data[%0d] got=%h exp=%h", i, data_log[i],
                             exp_pc[i] ^ KEY);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_req [3] = '{32'h0, 32'h4, 32'h500};
    int          bad = 0;
    do_reset(3, 1'b1);
    redirect_valid = 1'b1;   // still in reset wait: must be ignored
    redirect_addr  = 32'h300;
    step(1);
    redirect_valid = 1'b0;
    sample();
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL b2b_ignore_in_reset_wait got=%b/%h exp=1/0",
                           imem_req_valid, imem_req_addr);
    end
    step(2);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h400;
    step(1);
    redirect_addr  = 32'h500;
    step(1);
    redirect_valid = 1'b0;
    step(14);
    checks += 1;
    if (req_log.size() < 3) begin
      failures++; $display("FAIL b2b_req_count got=%0d exp>=3", req_log.size());
    end
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      checks += 1;
      if (req_log[i] !== exp_req[i]) begin
        failures++; $display("FAIL b2b_req_addr[%0d] got=%h exp=%h", i, req_log[i], exp_req[i]);
      end
    end
    foreach (req_log[i]) if (req_log[i] == 32'h300 || req_log[i] == 32'h400) bad++;
    checks += 2;
    if (bad !== 0) begin
      failures++; $display("FAIL b2b_stale_target_requests got=%0d exp=0", bad);
    end
    if (pc_log.size() < 2 || pc_log[0] !== 32'h500 || pc_log[1] !== 32'h504 ||
        data_log[0] !== (32'h500 ^ KEY) || data_log[1] !== (32'h504 ^ KEY)) begin
      failures++; $display("FAIL b2b_inst_stream got=%h,%h exp=500,504", pc_log[0], pc_log[1]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset(1, 1'b1);
    step(1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFF8;
    step(1);
    redirect_valid = 1'b0;
    step(8);
    checks += 1;
    if (req_log.size() < 3 || pc_log.size() < 3) begin
      failures++; $display("FAIL wrap_counts got=%0d/%0d exp>=3/3", req_log.size(), pc_log.size());
    end
    for (int i = 0; i < 3 && i < req_log.size() && i < pc_log.size(); i++) begin
      checks += 4;
      if (req_log[i] !== exp_pc[i]) begin
        failures++; $display("FAIL wrap_req_addr[%0d] got=%h exp=%h", i, req_log[i], exp_pc[i]);
      end
      if (req_cyc[i] !== 2 + i) begin
        failures++; $display("FAIL wrap_req_cycle[%0d] got=%0d exp=%0d", i, req_cyc[i], 2 + i);
      end
      if (pc_log[i] !== exp_pc[i]) begin
        failures++; $display("FAIL wrap_inst_pc[%0d] got=%h exp=%h", i, pc_log[i], exp_pc[i]);
      end
      if (data_log[i] !== (exp_pc[i] ^ KEY)) begin
        failures++; $display("FAIL wrap_inst_data[%0d] got=%h", i, data_log[i]);
      end
    end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset(1, 1'b1);
    step(4);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h102;
    step(1);
    redirect_valid = 1'b0;
    sample();
    checks += 3;
    if (fetch_fault !== 1'b1) begin
      failures++; $display("FAIL align_fault got=%b exp=1", fetch_fault);
    end
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL align_req_valid got=%b exp=0", imem_req_valid);
    end
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL align_inst_valid got=%b exp=0", inst_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      redirect_valid = (i == 1);   // aligned redirect in FAULT must be ignored
      redirect_addr  = 32'h400;
      sample();
      checks += 1;
      if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        failures++; $display("FAIL align_hold[%0d] fault=%b req=%b inst=%b exp=1,0,0",
                             i, fetch_fault, imem_req_valid, inst_valid);
      end
    end
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 1;
    if (fetch_fault !== 1'b0) begin
      failures++; $display("FAIL align_reset_clears got=%b exp=0", fetch_fault);
    end
  endtask
`else
  task automatic test_align();
    do_reset(1, 1'b1);
    step(1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h102;
    step(1);
    redirect_valid = 1'b0;
    sample();
    checks += 2;
    if (fetch_fault !== 1'b0) begin
      failures++; $display("FAIL align_fault_off got=%b exp=0", fetch_fault);
    end
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h102) begin
      failures++; $display("FAIL align_taken_as_is got=%b/%h exp=1/102",
                           imem_req_valid, imem_req_addr);
    end
    step(6);
    checks += 1;
    if (pc_log.size() < 2 || pc_log[0] !== 32'h102 || pc_log[1] !== 32'h106 ||
        data_log[0] !== (32'h102 ^ KEY)) begin
      failures++; $display("FAIL align_inst_stream got=%h,%h exp=102,106", pc_log[0], pc_log[1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_collision();
    test_back_to_back();
    test_wrap();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage feeding decode and consuming the branch/jump target address from the jump/branch logic. Holds the program counter, issues in-order instruction-memory requests under a credit limit, buffers returned instructions in a small FIFO and hands them downstream with their PC. On a redirect it flushes the buffer, discards in-flight responses and restarts fetching at the new target.

## Interface
- XLEN, 32: address/data width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- FIFO_DEPTH, 2: instruction buffer entries and the maximum number of outstanding requests. Must be a power of two, at least 2.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  take the target this cycle. Driven by the jump/branch logic when a jump or branch is taken.
- redirect_addr  in  XLEN  target address, from jump/branch logic address_out.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  response valid. Responses are in order, at least 1 cycle after the request and cannot be back-pressured.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  32  head instruction.
- inst_pc  out  XLEN  head PC.
- fetch_fault  out  1  misaligned redirect seen. Present only with FETCH_ALIGN_CHECK_EN, otherwise tied to 0.

## Operation
- State machine:
  - RESET_WAIT: reset state. Leaves to RUN on the first rising edge after rst_n deasserts.
  - RUN: normal fetching.
  - FAULT: entered only with FETCH_ALIGN_CHECK_EN. Left only by reset.
- pc register:
  - Reset value is RESET_PC.
  - imem_req_addr = pc.
  - imem_req_valid = (state==RUN) && (outstanding + fifo_count < FIFO_DEPTH) && !redirect_valid.
  - On a request handshake, pc <= pc + 4, modulo 2^XLEN (wraps from 0xFFFF_FFFC to 0).
- outstanding counter:
  - +1 on request handshake, -1 on imem_rsp_valid.
  - Both in one cycle: no change.
- Response handling:
  - If drop_cnt > 0, the response decrements drop_cnt and is discarded.
  - Otherwise {imem_rsp_data, rsp_pc} is written to the FIFO.
  - rsp_pc is a second counter advanced by 4 per accepted response. It loads redirect_addr on a redirect and RESET_PC on reset.
  - The credit rule guarantees the FIFO never overflows. A response arriving into a full FIFO is an assertion failure.
- FIFO:
  - The head drives inst_valid/inst_data/inst_pc.
  - The head pops on inst_valid && inst_ready.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- Redirect (redirect_valid=1 in RUN):
  - At the clock edge: FIFO cleared, pc and rsp_pc <= redirect_addr.
  - drop_cnt <= outstanding minus (1 if imem_rsp_valid this cycle).
  - imem_req_valid is forced low in the redirect cycle, so no old-stream request is accepted.
  - A response arriving in the redirect cycle is discarded.
  - A decode handshake in the redirect cycle still completes. The instruction was consumed before the flush.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each cycle.
  - Redirects in RESET_WAIT or FAULT are ignored.
- Reset mid-operation: all state is cleared asynchronously. Responses to requests issued before reset are the memory's responsibility and are not tracked.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - fetch_fault=0.
- First request: imem_req_valid rises at the first clock edge after rst_n release.
- Response to inst_valid: 1 cycle (registered FIFO write, no bypass).
- Redirect to the new-target request: imem_req_valid=1 with addr=redirect_addr in the cycle after redirect_valid, provided credit is available.
- Throughput: one instruction per cycle when memory latency is at most FIFO_DEPTH-1 cycles.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_addr[1:0] != 0 moves to FAULT instead of redirecting.
  - The FIFO is flushed and imem_req_valid is held 0.
  - fetch_fault is asserted from the next edge until reset.
- FETCH_ALIGN_CHECK_EN undefined:
  - No alignment check; redirect_addr is taken as-is.
  - FAULT is unreachable and fetch_fault is constant 0.

## Test plan
- Reset release, memory with ready=1 and 1-cycle latency, inst_ready=1 -> requests to 0x0, 0x4, 0x8 on consecutive cycles; inst_pc sequence 0x0, 0x4, 0x8 at one per cycle.
- inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, then imem_req_valid=0; releasing inst_ready resumes fetch with no lost or duplicated PC.
- 3-cycle memory latency with 2 requests outstanding, redirect_valid with redirect_addr=0x100 -> both stale responses dropped; next inst_pc=0x100; first request after the redirect is addr 0x100 one cycle later.
- Redirect in the same cycle as imem_rsp_valid and an inst handshake -> the handshaked instruction is delivered once, the response is discarded, drop_cnt = outstanding - 1.
- pc=0xFFFF_FFF8 via redirect -> requests to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- FETCH_ALIGN_CHECK_EN set, redirect_addr=0x102 -> fetch_fault=1 next cycle; imem_req_valid and inst_valid stay 0 until rst_n pulses low.
